// File: rtl/ca_frame_generator_if.sv
// Frame-generator control and buffer-write bundle.
// The generator drives the master side; the requester and buffer sit on the slave side.
interface ca_frame_generator_if;
  logic        start;
  logic [7:0]  rule;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;

  modport master (
    input  start, rule,
    output busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rule,
    input  busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ca_frame_generator.sv
// Elementary cellular automaton frame generator: 256 generations of 512 cells,
// streamed into the display buffer as 16-bit words (cell 16*word in bit 15).
module ca_frame_generator #(
  parameter int NUM_CELLS = 512,
  parameter int NUM_ROWS  = 256,
  parameter int SEED_POS  = 256,
  parameter int WRAP      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  ca_frame_generator_if.master bus
);
  localparam int WORDS = NUM_CELLS / 16;
  localparam logic [4:0] LAST_WORD = 5'(WORDS - 1);
  localparam logic [7:0] LAST_ROW  = 8'(NUM_ROWS - 1);
  localparam logic [NUM_CELLS-1:0] SEED = {{(NUM_CELLS-1){1'b0}}, 1'b1} << SEED_POS;

  typedef enum logic [1:0] {IDLE, WRITE, COMPUTE, DONE} state_t;

  state_t               state;
  logic [NUM_CELLS-1:0] cells;
  logic [NUM_CELLS-1:0] cells_next;
  logic [7:0]           rule_q;
  logic [7:0]           row;
  logic [4:0]           word;

  // Lowest-numbered cell of the word lands in the MSB, matching the driver's bit = ~x[3:0].
  function automatic logic [15:0] word_bits(input logic [NUM_CELLS-1:0] gen, input logic [4:0] w);
    logic [15:0] seg;
    logic [15:0] res;
    seg = gen[{w, 4'b0000} +: 16];
    for (int i = 0; i < 16; i++) res[15-i] = seg[i];
    return res;
  endfunction

  // ext[c+1] is cell c; the two pad bits stand in for cells -1 and NUM_CELLS.
  function automatic logic [NUM_CELLS-1:0] next_gen(input logic [NUM_CELLS-1:0] gen,
                                                   input logic [7:0] r);
    logic [NUM_CELLS+1:0] ext;
    logic [NUM_CELLS-1:0] nxt;
    logic                 pad_lo;
    logic                 pad_hi;
    pad_lo = (WRAP != 0) ? gen[NUM_CELLS-1] : 1'b0;
    pad_hi = (WRAP != 0) ? gen[0] : 1'b0;
    ext = {pad_hi, gen, pad_lo};
    for (int c = 0; c < NUM_CELLS; c++) nxt[c] = r[{ext[c], ext[c+1], ext[c+2]}];
    return nxt;
  endfunction

  always_comb cells_next = next_gen(cells, rule_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cells       <= '0;
      rule_q      <= '0;
      row         <= '0;
      word        <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rule_q      <= bus.rule;
            cells       <= SEED;
            row         <= '0;
            word        <= '0;
            bus.busy    <= 1'b1;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= '0;
            bus.wr_data <= word_bits(SEED, 5'd0);
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (word == LAST_WORD) begin
            bus.wr_en <= 1'b0;
            if (row == LAST_ROW) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              state <= COMPUTE;
            end
          end else begin
            word        <= word + 5'd1;
            bus.wr_addr <= {row, word + 5'd1};
            bus.wr_data <= word_bits(cells, word + 5'd1);
          end
        end
        COMPUTE: begin
          cells       <= cells_next;
          row         <= row + 8'd1;
          word        <= '0;
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= {row + 8'd1, 5'd0};
          bus.wr_data <= word_bits(cells_next, 5'd0);
          state       <= WRITE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
